// File: rtl/oled_fb_pkg.sv
// Shared constants, FSM encoding and helpers for the OLED frame buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package oled_fb_pkg;

    localparam int COLS       = 128;
    localparam int PAGES      = 4;
    localparam int BANK_BYTES = COLS * PAGES;  // 512 bytes per bank
    localparam int ADDR_W     = 9;             // byte address within one bank
    localparam int GLYPH_W    = 4;             // glyph ROM index width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FETCH = 2'd2,
        ST_WRITE = 2'd3
    } fb_state_t;

    // Mirror a column byte so bit0 (top pixel) becomes bit7.
    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/oled_glyph_rom.sv
// Glyph ROM: 8x8 column-byte font (hex digits 0-F), bit0 = top pixel of the page.
// Latency: 1 cycle from glyph/col to dat.
// Backpressure: none; a new column can be addressed every cycle.
// Ports: clk; glyph = ROM entry; col = column 0..7; dat = registered column byte.
module oled_glyph_rom
    import oled_fb_pkg::*;
#(
    parameter int GLYPHS = 16
) (
    input  logic               clk,
    input  logic [GLYPH_W-1:0] glyph,
    input  logic [2:0]         col,
    output logic [7:0]         dat
);

    // Column k of a glyph lives in bits [8k+7:8k]. Column 0 and columns 6..7
    // are blank so adjacent tiles keep a gap between characters.
    function automatic logic [63:0] font(input logic [GLYPH_W-1:0] g);
        logic [63:0] f;
        case (g)
            4'h0:    f = 64'h00003E4549513E00;
            4'h1:    f = 64'h000000407F420000;
            4'h2:    f = 64'h0000464951614200;
            4'h3:    f = 64'h0000314B45412100;
            4'h4:    f = 64'h0000107F12141800;
            4'h5:    f = 64'h0000394545452700;
            4'h6:    f = 64'h00003049494A3C00;
            4'h7:    f = 64'h0000030509710100;
            4'h8:    f = 64'h0000364949493600;
            4'h9:    f = 64'h00001E2949490600;
            4'hA:    f = 64'h00007E1111117E00;
            4'hB:    f = 64'h0000364949497F00;
            4'hC:    f = 64'h0000224141413E00;
            4'hD:    f = 64'h00001C2241417F00;
            4'hE:    f = 64'h0000414949497F00;
            default: f = 64'h0000010909097F00;
        endcase
        return f;
    endfunction

    logic [63:0] glyph_bits;

    // Entries beyond the configured glyph count read as blank.
    always_comb begin
        glyph_bits = (int'(glyph) < GLYPHS) ? font(glyph) : 64'd0;
    end

    always_ff @(posedge clk) begin
        dat <= glyph_bits[{col, 3'b000} +: 8];
    end

endmodule

// File: rtl/oled_frame_buffer.sv
// Double-buffered 128x32 OLED frame buffer with glyph-blit / clear engine on the back bank.
// Latency: rd_data 1 cycle after rd_index; clear 512 busy cycles, glyph draw 9 busy cycles.
// Backpressure: requests while busy are dropped; swap deferred to frame_done with engine idle.
// Ports: clk/rst (sync, active-high); rd_index/rd_data = streamer read of front bank;
//        frame_done = end of streamed frame; clear_req/draw_req + draw_* = engine commands;
//        commit = request swap; busy/swap_pending/active_bank = status.
// Option: define OLED_FB_ROTATE180_EN for a panel mounted upside down
//         (read index mirrored to 511-rd_index and rd_data bit-reversed, same latency).
module oled_frame_buffer #(
    parameter int COLS   = 128,
    parameter int PAGES  = 4,
    parameter int GLYPHS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rd_index,
    output logic [7:0] rd_data,
    input  logic       frame_done,
    input  logic       clear_req,
    input  logic       draw_req,
    input  logic [3:0] draw_tile,
    input  logic [1:0] draw_page,
    input  logic [3:0] draw_glyph,
    input  logic       draw_invert,
    input  logic       commit,
    output logic       busy,
    output logic       swap_pending,
    output logic       active_bank
);

    import oled_fb_pkg::*;

    localparam int FB_BYTES = COLS * PAGES;

    fb_state_t          state;
    logic [ADDR_W-1:0]  cnt;
    logic [3:0]         lat_tile;
    logic [1:0]         lat_page;
    logic [GLYPH_W-1:0] lat_glyph;
    logic               lat_invert;

    // Both banks in one array; the bank select is the MSB of the address.
    logic [7:0]         mem [2*BANK_BYTES];

    logic [2:0]         rom_col;
    logic [7:0]         rom_dat;

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [7:0]         wr_dat;

    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_in_range;

    oled_glyph_rom #(
        .GLYPHS (GLYPHS)
    ) u_rom (
        .clk   (clk),
        .glyph (lat_glyph),
        .col   (rom_col),
        .dat   (rom_dat)
    );

    // The ROM is one cycle behind: FETCH presents column 0 and each WRITE
    // cycle k presents column k+1, so rom_dat holds column k during WRITE k.
    always_comb begin
        rom_col = (state == ST_WRITE) ? (cnt[2:0] + 3'd1) : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            cnt          <= '0;
            lat_tile     <= '0;
            lat_page     <= '0;
            lat_glyph    <= '0;
            lat_invert   <= 1'b0;
            swap_pending <= 1'b0;
            active_bank  <= 1'b0;
        end else begin
            // Uses the registered pending flag, so a commit arriving together
            // with frame_done only arms the swap for the following frame.
            if (swap_pending && frame_done && state == ST_IDLE) begin
                active_bank  <= ~active_bank;
                swap_pending <= 1'b0;
            end else if (commit) begin
                swap_pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end else if (draw_req) begin
                        state      <= ST_FETCH;
                        busy       <= 1'b1;
                        lat_tile   <= draw_tile;
                        lat_page   <= draw_page;
                        lat_glyph  <= draw_glyph;
                        lat_invert <= draw_invert;
                    end
                end
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(FB_BYTES - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state <= ST_WRITE;
                    cnt   <= '0;
                end
                ST_WRITE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt[2:0] == 3'd7) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Back-bank write port. {page, tile, k} is exactly page*128 + tile*8 + k.
    // Gated by rst so an aborted blit does not write on the reset edge.
    always_comb begin
        wr_en   = !rst && (state == ST_CLEAR || state == ST_WRITE);
        wr_addr = cnt;
        wr_dat  = 8'h00;
        if (state == ST_WRITE) begin
            wr_addr = {lat_page, lat_tile, cnt[2:0]};
            wr_dat  = rom_dat ^ {8{lat_invert}};
        end
    end

    // The engine only writes the back bank and a swap can only happen while
    // idle, so the read and write ports never address the same bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{~active_bank, wr_addr}] <= wr_dat;
        end
    end

    always_comb begin
`ifdef OLED_FB_ROTATE180_EN
        rd_addr = ADDR_W'(FB_BYTES - 1) - rd_index[ADDR_W-1:0];
`else
        rd_addr = rd_index[ADDR_W-1:0];
`endif
        rd_in_range = (rd_index < 10'(FB_BYTES));
    end

    always_ff @(posedge clk) begin
        if (rst || !rd_in_range) begin
            rd_data <= 8'h00;
        end else begin
`ifdef OLED_FB_ROTATE180_EN
            rd_data <= bit_rev8(mem[{active_bank, rd_addr}]);
`else
            rd_data <= mem[{active_bank, rd_addr}];
`endif
        end
    end

endmodule
